// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V control path: FSM states, opcodes,
// ALUOp codes (also used by the ALU decoder) and datapath mux-select codes.
package rv_ctrl_pkg;

    localparam int unsigned OP_W = 7;
    localparam int unsigned ST_W = 4;

    typedef enum logic [ST_W-1:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXEC_R,
        S_EXEC_I,
        S_ALUWB,
        S_BEQ,
        S_JAL
    } state_t;

    localparam logic [OP_W-1:0] OP_LW  = 7'b0000011;
    localparam logic [OP_W-1:0] OP_SW  = 7'b0100011;
    localparam logic [OP_W-1:0] OP_R   = 7'b0110011;
    localparam logic [OP_W-1:0] OP_I   = 7'b0010011;
    localparam logic [OP_W-1:0] OP_BEQ = 7'b1100011;
    localparam logic [OP_W-1:0] OP_JAL = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    function automatic logic is_legal(input logic [OP_W-1:0] op);
        return (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
               (op == OP_I) || (op == OP_BEQ) || (op == OP_JAL);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath/memory signal bundle. The controller side is master.
interface multicycle_ctrl_if;
    import rv_ctrl_pkg::*;

    logic [OP_W-1:0] opcode;
    logic            zero;
    logic            mem_ready;
    logic            pc_write;
    logic            adr_src;
    logic            mem_req;
    logic            mem_write;
    logic            ir_write;
    logic [1:0]      result_src;
    logic [1:0]      alu_src_a;
    logic [1:0]      alu_src_b;
    logic [1:0]      alu_op;
    logic            reg_write;
    logic            illegal;

    modport master (
        input  opcode, zero, mem_ready,
        output pc_write, adr_src, mem_req, mem_write, ir_write, result_src,
               alu_src_a, alu_src_b, alu_op, reg_write, illegal
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pc_write, adr_src, mem_req, mem_write, ir_write, result_src,
               alu_src_a, alu_src_b, alu_op, reg_write, illegal
    );

endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle RISC-V control FSM: state register, next-state logic and Moore
// output table, with memory-ready stalls and a sticky illegal-opcode flag.
module multicycle_ctrl
    import rv_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    multicycle_ctrl_if.master bus
);

    state_t     state, state_nxt;
    logic       illegal_q, illegal_set;
    logic       pc_update, branch;
    logic       adr_src, mem_req, mem_write, ir_write, reg_write;
    logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (illegal_set) illegal_q <= 1'b1;
        end
    end

    always_comb begin
        state_nxt   = state;
        illegal_set = 1'b0;
        pc_update   = 1'b0;
        branch      = 1'b0;
        adr_src     = 1'b0;
        mem_req     = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        reg_write   = 1'b0;
        result_src  = RES_ALUOUT;
        alu_src_a   = SRCA_PC;
        alu_src_b   = SRCB_RS2;
        alu_op      = ALUOP_ADD;
        case (state)
            S_FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURESULT;
                ir_write   = bus.mem_ready;
                pc_update  = bus.mem_ready;
                if (bus.mem_ready) state_nxt = S_DECODE;
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                case (bus.opcode)
                    OP_LW, OP_SW: state_nxt = S_MEMADR;
                    OP_R:         state_nxt = S_EXEC_R;
                    OP_I:         state_nxt = S_EXEC_I;
                    OP_BEQ:       state_nxt = S_BEQ;
                    OP_JAL:       state_nxt = S_JAL;
                    default:      state_nxt = S_FETCH;
                endcase
                illegal_set = !is_legal(bus.opcode);
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                if (bus.opcode == OP_LW)      state_nxt = S_MEMREAD;
                else if (bus.opcode == OP_SW) state_nxt = S_MEMWRITE;
                else                          state_nxt = S_FETCH;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                mem_req = 1'b1;
                if (bus.mem_ready) state_nxt = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = RES_DATA;
                reg_write  = 1'b1;
                state_nxt  = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_req   = 1'b1;
                mem_write = 1'b1;
                if (bus.mem_ready) state_nxt = S_FETCH;
            end
            S_EXEC_R: begin
                alu_src_a = SRCA_RS1;
                alu_op    = ALUOP_FUNCT;
                state_nxt = S_ALUWB;
            end
            S_EXEC_I: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_FUNCT;
                state_nxt = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                state_nxt = S_FETCH;
            end
            S_BEQ: begin
                alu_src_a = SRCA_RS1;
                alu_op    = ALUOP_SUB;
                branch    = 1'b1;
                state_nxt = S_FETCH;
            end
            S_JAL: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_FOUR;
                pc_update = 1'b1;
                state_nxt = S_ALUWB;
            end
            default: state_nxt = S_FETCH;
        endcase
    end

    // Outputs are forced low while reset is held so an aborted access or write
    // never reaches the datapath, even though the state register reads FETCH.
    assign bus.pc_write   = rst_n & (pc_update | (branch & bus.zero));
    assign bus.adr_src    = rst_n & adr_src;
    assign bus.mem_req    = rst_n & mem_req;
    assign bus.mem_write  = rst_n & mem_write;
    assign bus.ir_write   = rst_n & ir_write;
    assign bus.reg_write  = rst_n & reg_write;
    assign bus.result_src = rst_n ? result_src : '0;
    assign bus.alu_src_a  = rst_n ? alu_src_a  : '0;
    assign bus.alu_src_b  = rst_n ? alu_src_b  : '0;
    assign bus.alu_op     = rst_n ? alu_op     : '0;
    assign bus.illegal    = illegal_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle output vectors against
// hand-written expectations for every instruction class, stalls and reset.
module tb_multicycle_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    multicycle_ctrl_if bus();

    multicycle_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Vector layout: pc_write adr_src mem_req mem_write ir_write
    //                result_src[1:0] alu_src_a[1:0] alu_src_b[1:0] alu_op[1:0] reg_write
    localparam logic [13:0] V_ZERO     = 14'b0_0_0_0_0_00_00_00_00_0;
    localparam logic [13:0] V_FETCH_OK = 14'b1_0_1_0_1_10_00_10_00_0;
    localparam logic [13:0] V_FETCH_ST = 14'b0_0_1_0_0_10_00_10_00_0;
    localparam logic [13:0] V_DECODE   = 14'b0_0_0_0_0_00_01_01_00_0;
    localparam logic [13:0] V_MEMADR   = 14'b0_0_0_0_0_00_10_01_00_0;
    localparam logic [13:0] V_MEMREAD  = 14'b0_1_1_0_0_00_00_00_00_0;
    localparam logic [13:0] V_MEMWB    = 14'b0_0_0_0_0_01_00_00_00_1;
    localparam logic [13:0] V_MEMWRITE = 14'b0_1_1_1_0_00_00_00_00_0;
    localparam logic [13:0] V_EXEC_R   = 14'b0_0_0_0_0_00_10_00_10_0;
    localparam logic [13:0] V_EXEC_I   = 14'b0_0_0_0_0_00_10_01_10_0;
    localparam logic [13:0] V_ALUWB    = 14'b0_0_0_0_0_00_00_00_00_1;
    localparam logic [13:0] V_BEQ_T    = 14'b1_0_0_0_0_00_10_00_01_0;
    localparam logic [13:0] V_BEQ_NT   = 14'b0_0_0_0_0_00_10_00_01_0;
    localparam logic [13:0] V_JAL      = 14'b1_0_0_0_0_00_01_10_00_0;

    function automatic logic [13:0] outv();
        return {bus.pc_write, bus.adr_src, bus.mem_req, bus.mem_write, bus.ir_write,
                bus.result_src, bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.reg_write};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called just after a rising edge; drives inputs, checks at the falling edge.
    task automatic cyc(input string tag, input logic rdy, input logic z, input logic [13:0] exp);
        bus.mem_ready = rdy;
        bus.zero      = z;
        @(negedge clk);
        check(tag, {18'b0, outv()}, {18'b0, exp});
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.opcode    = 7'b0110011;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b0;
        #1;
        check("reset_out", {18'b0, outv()}, 32'h0);
        check("reset_ill", {31'b0, bus.illegal}, 32'h0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // R-type add, zero held high to catch pc_write leaks
        bus.opcode = 7'b0110011;
        cyc("r_fetch",  1'b1, 1'b1, V_FETCH_OK);
        cyc("r_decode", 1'b1, 1'b1, V_DECODE);
        cyc("r_exec",   1'b1, 1'b1, V_EXEC_R);
        cyc("r_wb",     1'b1, 1'b1, V_ALUWB);

        // LW with two stall cycles in FETCH and MEMREAD: 9 cycles
        bus.opcode = 7'b0000011;
        cyc("lw_fst0",  1'b0, 1'b0, V_FETCH_ST);
        cyc("lw_fst1",  1'b0, 1'b0, V_FETCH_ST);
        cyc("lw_fetch", 1'b1, 1'b0, V_FETCH_OK);
        cyc("lw_dec",   1'b0, 1'b0, V_DECODE);
        cyc("lw_adr",   1'b0, 1'b0, V_MEMADR);
        cyc("lw_rst0",  1'b0, 1'b0, V_MEMREAD);
        cyc("lw_rst1",  1'b0, 1'b0, V_MEMREAD);
        cyc("lw_rd",    1'b1, 1'b0, V_MEMREAD);
        cyc("lw_wb",    1'b0, 1'b0, V_MEMWB);

        // BEQ taken, then not taken
        bus.opcode = 7'b1100011;
        cyc("beq_t_fetch", 1'b1, 1'b0, V_FETCH_OK);
        cyc("beq_t_dec",   1'b1, 1'b0, V_DECODE);
        cyc("beq_t_exec",  1'b1, 1'b1, V_BEQ_T);
        cyc("beq_n_fetch", 1'b1, 1'b0, V_FETCH_OK);
        cyc("beq_n_dec",   1'b1, 1'b0, V_DECODE);
        cyc("beq_n_exec",  1'b1, 1'b0, V_BEQ_NT);

        // SW
        bus.opcode = 7'b0100011;
        cyc("sw_fetch", 1'b1, 1'b0, V_FETCH_OK);
        cyc("sw_dec",   1'b1, 1'b0, V_DECODE);
        cyc("sw_adr",   1'b1, 1'b0, V_MEMADR);
        cyc("sw_wr",    1'b1, 1'b0, V_MEMWRITE);

        // I-type
        bus.opcode = 7'b0010011;
        cyc("i_fetch", 1'b1, 1'b0, V_FETCH_OK);
        cyc("i_dec",   1'b1, 1'b0, V_DECODE);
        cyc("i_exec",  1'b1, 1'b0, V_EXEC_I);
        cyc("i_wb",    1'b1, 1'b0, V_ALUWB);

        // JAL
        bus.opcode = 7'b1101111;
        cyc("jal_fetch", 1'b1, 1'b0, V_FETCH_OK);
        cyc("jal_dec",   1'b1, 1'b0, V_DECODE);
        cyc("jal_exec",  1'b1, 1'b0, V_JAL);
        cyc("jal_wb",    1'b1, 1'b0, V_ALUWB);

        // Illegal opcode: sticky flag, decode returns straight to FETCH
        bus.opcode = 7'b1111111;
        cyc("ill_fetch", 1'b1, 1'b0, V_FETCH_OK);
        check("ill_pre", {31'b0, bus.illegal}, 32'h0);
        cyc("ill_dec",   1'b1, 1'b0, V_DECODE);
        check("ill_set", {31'b0, bus.illegal}, 32'h1);
        bus.opcode = 7'b0110011;
        cyc("ill_r_fetch", 1'b1, 1'b0, V_FETCH_OK);
        cyc("ill_r_dec",   1'b1, 1'b0, V_DECODE);
        cyc("ill_r_exec",  1'b1, 1'b0, V_EXEC_R);
        cyc("ill_r_wb",    1'b1, 1'b0, V_ALUWB);
        check("ill_sticky", {31'b0, bus.illegal}, 32'h1);

        // Async reset in the middle of a stalled store
        bus.opcode = 7'b0100011;
        cyc("rs_fetch", 1'b1, 1'b0, V_FETCH_OK);
        cyc("rs_dec",   1'b1, 1'b0, V_DECODE);
        cyc("rs_adr",   1'b0, 1'b0, V_MEMADR);
        cyc("rs_stall", 1'b0, 1'b0, V_MEMWRITE);
        #2;
        rst_n = 1'b0;
        #1;
        check("rs_out", {18'b0, outv()}, {18'b0, V_ZERO});
        check("rs_ill", {31'b0, bus.illegal}, 32'h0);
        @(posedge clk);
        #1;
        check("rs_hold", {18'b0, outv()}, {18'b0, V_ZERO});
        rst_n = 1'b1;
        bus.opcode = 7'b0110011;
        cyc("post_fetch", 1'b1, 1'b0, V_FETCH_OK);
        cyc("post_dec",   1'b1, 1'b0, V_DECODE);
        cyc("post_exec",  1'b1, 1'b0, V_EXEC_R);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
